axi_lite_host_master: RTL and testbench
=======================================

# axi_lite_host_master

AXI-Lite initiator that drives the accelerator's 4-bit-address control-register slave from on-chip logic: it issues the `s_axi_*` writes and reads that the host side otherwise performs. It accepts one command at a time on a valid/ready command port, runs the matching AXI-Lite write or read, and returns completion and read data on a valid/ready response port. A programmable watchdog aborts hung transactions. It is intended for a microsequencer or for self-test logic, so inference can be started and polled without an external host.

## Interface
- `DATA_WIDTH`, 32, AXI data width and command write-data width.
- `AXI_ADDR_WIDTH`, 4, register address width.
- `TIMEOUT_CYCLES`, 64, number of bus-phase cycles before abort; 0 disables the watchdog.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on `cmd_valid && cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  AXI_ADDR_WIDTH  register address.
- `cmd_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed on `rsp_valid && rsp_ready`.
- `rsp_write`  out  1  echo of `cmd_write`.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and for aborted transactions.
- `rsp_err`  out  1  1 = watchdog abort.
- `m_axi_awaddr` out AXI_ADDR_WIDTH, `m_axi_awvalid` out 1, `m_axi_awready` in 1.
- `m_axi_wdata` out DATA_WIDTH, `m_axi_wvalid` out 1, `m_axi_wready` in 1.
- `m_axi_araddr` out AXI_ADDR_WIDTH, `m_axi_arvalid` out 1, `m_axi_arready` in 1.
- `m_axi_rdata` in DATA_WIDTH, `m_axi_rvalid` in 1, `m_axi_rready` out 1.
- The slave has no B channel. A write completes once both the AW and W handshakes have occurred.

## Operation
- FSM states: IDLE, WR, RD_ADDR, RD_DATA, RESP.
- **IDLE**
  - `cmd_ready = 1` here only, and forced to 0 while `rst` is high.
  - On accept, the block latches addr, wdata and write, clears the watchdog, then goes to WR (write) or RD_ADDR (read).
- **WR**
  - `awvalid` and `wvalid` assert together.
  - Each valid drops independently, the cycle after its own handshake. Internal flags `aw_done` and `w_done` track this.
  - When both flags are set, go to RESP with `rsp_err = 0`.
- **RD_ADDR**
  - `arvalid` is held until `arready`, then go to RD_DATA.
- **RD_DATA**
  - `rready = 1`.
  - On `rvalid`, capture `rdata` into `rsp_rdata` and go to RESP.
- **RESP**
  - `rsp_valid = 1`. Response fields are held stable until `rsp_ready`, then go to IDLE.
- **Watchdog**
  - Counts every cycle spent in WR, RD_ADDR or RD_DATA.
  - On reaching `TIMEOUT_CYCLES`, the block deasserts all AXI valids and `rready`, sets `rsp_err = 1` and `rsp_rdata = 0`, and goes to RESP.
  - This is a deliberate recovery deviation from the AXI rule that valid must hold until ready.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.
- **Simultaneous events:** a handshake in the same cycle as watchdog expiry wins, so the transaction completes normally.
- **Reset values:** all AXI valids, `rready`, `rsp_valid`, `rsp_err`, `rsp_write`, `rsp_rdata`, `awaddr`, `araddr` and `wdata` are 0. State is IDLE.
- **Reset mid-transaction:** all valids drop immediately (asynchronously) and no response is produced.

## Timing
- All outputs are registered, except `cmd_ready`, which is decoded from state and `rst`.
- The command is accepted at edge 0.
- **Write:** AW and W valids are high in cycle 1. With zero-wait ready, `rsp_valid` is high in cycle 2.
- **Read:** `arvalid` is high in cycle 1 and `rready` in cycle 2. With zero-wait ready and `rvalid` in cycle 2, `rsp_valid` is high in cycle 3.
- After the response handshake, `cmd_ready` is high the next cycle. Throughput is one command per 3 cycles minimum for writes and 4 for reads.

## Structure
- Shared package `accel_axi_pkg`:
  - FSM state enum.
  - Register offsets: CTRL = 0x0, 0x8 = layer-count register, 0xC = precision-mode register (0 = INT8).
  - Default `TIMEOUT_CYCLES`.
- One sub-module, `axi_watchdog_ctr`, with clear, enable and expired outputs.

## Test plan
- **Immediate-ready write:** write 0x8 ← 1 with all readies tied high. Require `awaddr = 0x8` and `wdata = 1` in cycle 1, `rsp_valid` in cycle 2, `rsp_err = 0`.
- **Skewed write handshakes:** `wready` in cycle 1, `awready` in cycle 3. Require `wvalid` low from cycle 2, `awvalid` held through cycle 3, `rsp_valid` in cycle 4.
- **Delayed read:** read 0x0 with `arready` in cycle 1 and `rvalid` in cycle 6 with `rdata = 0x50`. Require `rsp_rdata = 0x50` and `rsp_valid` in cycle 7.
- **Response backpressure:** hold `rsp_ready` low for 4 cycles. Require response fields stable and `cmd_ready = 0` throughout; the next command is accepted the cycle after the response handshake.
- **Watchdog abort:** `TIMEOUT_CYCLES = 16` with the slave never ready. Require valids low and `rsp_err = 1`, `rsp_rdata = 0` after 16 bus cycles. A follow-up write with a responsive slave succeeds. With `awready` arriving exactly on the expiry cycle, require `rsp_err = 0`.
- **Reset mid-read:** assert `rst` while in RD_DATA. Require `arvalid`, `rready` and `rsp_valid` low immediately, and `cmd_ready = 1` one cycle after deassertion.

Source files
------------

// File: rtl/accel_axi_pkg.sv
// Shared definitions for the accelerator AXI-Lite control path.
package accel_axi_pkg;

    // Host master sequencing states
    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    // Control-register slave offsets
    localparam logic [3:0] REG_CTRL      = 4'h0;
    localparam logic [3:0] REG_LAYER_CNT = 4'h8;
    localparam logic [3:0] REG_PREC_MODE = 4'hC;

    // Precision-mode encoding
    localparam logic [31:0] PREC_INT8 = 32'd0;

    // Bus-phase cycles allowed before a transaction is abandoned
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/axi_watchdog_ctr.sv
// Saturating bus-phase cycle counter; flags expiry in the last permitted cycle.
module axi_watchdog_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SAT   = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0] cnt;

    // Count enabled cycles, holding at the limit instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry stays asserted once reached, so a late phase after a saturated count still aborts
    always_comb begin
        expired = (TIMEOUT_CYCLES != 0) && enable && (cnt >= LIMIT);
    end

endmodule

// File: rtl/axi_lite_host_master.sv
// AXI-Lite initiator: one command at a time, runs the write/read, returns a response.
module axi_lite_host_master
    import accel_axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    state_t                    state, state_nxt;
    logic                      aw_done, aw_done_nxt, w_done, w_done_nxt;
    logic                      awvalid_nxt, wvalid_nxt, arvalid_nxt, rready_nxt;
    logic                      rsp_valid_nxt, rsp_write_nxt, rsp_err_nxt;
    logic [DATA_WIDTH-1:0]     rsp_rdata_nxt, wdata_nxt;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_nxt, araddr_nxt;
    logic                      accept, wd_en, wd_expired;
    logic                      aw_hs, w_hs, aw_fin, w_fin;

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign wd_en     = (state == WR) || (state == RD_ADDR) || (state == RD_DATA);

    axi_watchdog_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (wd_en),
        .expired(wd_expired)
    );

    // State and registered-output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= '0;
        end else begin
            state         <= state_nxt;
            aw_done       <= aw_done_nxt;
            w_done        <= w_done_nxt;
            m_axi_awvalid <= awvalid_nxt;
            m_axi_wvalid  <= wvalid_nxt;
            m_axi_arvalid <= arvalid_nxt;
            m_axi_rready  <= rready_nxt;
            m_axi_awaddr  <= awaddr_nxt;
            m_axi_araddr  <= araddr_nxt;
            m_axi_wdata   <= wdata_nxt;
            rsp_valid     <= rsp_valid_nxt;
            rsp_write     <= rsp_write_nxt;
            rsp_err       <= rsp_err_nxt;
            rsp_rdata     <= rsp_rdata_nxt;
        end
    end

    // Next-state and next-output decode; a handshake takes priority over watchdog expiry
    always_comb begin
        state_nxt     = state;
        aw_done_nxt   = aw_done;
        w_done_nxt    = w_done;
        awvalid_nxt   = m_axi_awvalid;
        wvalid_nxt    = m_axi_wvalid;
        arvalid_nxt   = m_axi_arvalid;
        rready_nxt    = m_axi_rready;
        awaddr_nxt    = m_axi_awaddr;
        araddr_nxt    = m_axi_araddr;
        wdata_nxt     = m_axi_wdata;
        rsp_valid_nxt = rsp_valid;
        rsp_write_nxt = rsp_write;
        rsp_err_nxt   = rsp_err;
        rsp_rdata_nxt = rsp_rdata;
        aw_hs         = m_axi_awvalid && m_axi_awready;
        w_hs          = m_axi_wvalid && m_axi_wready;
        aw_fin        = aw_done || aw_hs;
        w_fin         = w_done || w_hs;

        case (state)
            IDLE: begin
                if (accept) begin
                    rsp_write_nxt = cmd_write;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = '0;
                    aw_done_nxt   = 1'b0;
                    w_done_nxt    = 1'b0;
                    if (cmd_write) begin
                        awaddr_nxt  = cmd_addr;
                        wdata_nxt   = cmd_wdata;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = WR;
                    end else begin
                        araddr_nxt  = cmd_addr;
                        arvalid_nxt = 1'b1;
                        state_nxt   = RD_ADDR;
                    end
                end
            end
            WR: begin
                aw_done_nxt = aw_fin;
                w_done_nxt  = w_fin;
                awvalid_nxt = m_axi_awvalid && !aw_hs;
                wvalid_nxt  = m_axi_wvalid && !w_hs;
                if (aw_fin && w_fin) begin
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (wd_expired) begin
                    awvalid_nxt   = 1'b0;
                    wvalid_nxt    = 1'b0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_DATA;
                end else if (wd_expired) begin
                    arvalid_nxt   = 1'b0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rsp_rdata_nxt = m_axi_rdata;
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (wd_expired) begin
                    rready_nxt    = 1'b0;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_host_master.sv
// Directed plus randomized checks of the AXI-Lite host master against a cycle-level transaction model.
module tb_axi_lite_host_master;

    localparam int T = 16;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic [3:0]  awaddr, araddr;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [31:0] wdata, rdata = '0;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_host_master #(
        .DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(4),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction. Ready cycles are bus-cycle indices (1 = first cycle after accept), 0 = never.
    // Model: the response appears one cycle after the last needed handshake if that is within T
    // bus cycles, otherwise in cycle T+1 as an error with zero data.
    task automatic run_txn(input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int aw_c, input int w_c,
                           input int ar_c, input int r_c, input int rwait);
        int awe, we, are, rve, done_c, rsp_c;
        bit ok;
        logic [31:0] exp_rdata;
        awe = (aw_c == 0) ? NEVER : aw_c;
        we  = (w_c  == 0) ? NEVER : w_c;
        are = (ar_c == 0) ? NEVER : ar_c;
        rve = (r_c  == 0) ? NEVER : r_c;
        if (wr) done_c = (awe > we) ? awe : we;
        else    done_c = (are <= T) ? rve : NEVER;
        ok = (done_c <= T);
        rsp_c = ok ? done_c + 1 : T + 1;
        exp_rdata = (!wr && ok) ? rd : 32'h0;

        chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = $urandom_range(0, 1);
        cmd_addr = 4'($urandom); cmd_wdata = $urandom;

        for (int c = 1; c <= rsp_c + rwait; c++) begin
            chk("awvalid", 32'(awvalid), 32'(wr && c < rsp_c && c <= awe));
            chk("wvalid",  32'(wvalid),  32'(wr && c < rsp_c && c <= we));
            chk("arvalid", 32'(arvalid), 32'(!wr && c < rsp_c && c <= are));
            chk("rready",  32'(rready),  32'(!wr && c < rsp_c && c > are));
            chk("rsp_valid", 32'(rsp_valid), 32'(c >= rsp_c));
            chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (c == 1) begin
                if (wr) begin
                    chk("awaddr", 32'(awaddr), 32'(addr));
                    chk("wdata", wdata, wd);
                end else begin
                    chk("araddr", 32'(araddr), 32'(addr));
                end
            end
            if (c >= rsp_c) begin
                chk("rsp_write", 32'(rsp_write), 32'(wr));
                chk("rsp_err",   32'(rsp_err),   32'(!ok));
                chk("rsp_rdata", rsp_rdata, exp_rdata);
            end
            awready   = (c == aw_c);
            wready    = (c == w_c);
            arready   = (c == ar_c);
            rvalid    = (c == r_c);
            rdata     = (c == r_c) ? rd : $urandom;
            rsp_ready = (c == rsp_c + rwait);
            @(posedge clk); #1;
        end
        awready = 0; wready = 0; arready = 0; rvalid = 0; rsp_ready = 0;
        chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, rready, rsp_valid}), 32'd0);
        chk("rst_rsp", 32'({rsp_err, rsp_write}), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_addrs", 32'({awaddr, araddr}), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Immediate-ready write: layer count <- 1
        run_txn(1'b1, 4'h8, 32'h1, 32'h0, 1, 1, 0, 0, 0);
        // Skewed write handshakes
        run_txn(1'b1, 4'hC, 32'h0, 32'h0, 3, 1, 0, 0, 0);
        // Delayed read of CTRL
        run_txn(1'b0, 4'h0, 32'h0, 32'h50, 0, 0, 1, 6, 0);
        // Immediate read
        run_txn(1'b0, 4'h4, 32'h0, 32'hDEADBEEF, 0, 0, 1, 2, 0);
        // Response backpressure, next command straight after the handshake
        run_txn(1'b0, 4'h8, 32'h0, 32'h12345678, 0, 0, 2, 3, 4);
        run_txn(1'b1, 4'h0, 32'hA5A5A5A5, 32'h0, 1, 1, 0, 0, 4);
        // Watchdog aborts: slave never ready
        run_txn(1'b1, 4'h8, 32'h77, 32'h0, 0, 0, 0, 0, 0);
        run_txn(1'b0, 4'h0, 32'h0, 32'h99, 0, 0, 0, 0, 1);
        run_txn(1'b0, 4'h4, 32'h0, 32'h99, 0, 0, 1, 0, 0);
        run_txn(1'b1, 4'h4, 32'h55, 32'h0, 0, 2, 0, 0, 0);
        // Follow-up write with a responsive slave
        run_txn(1'b1, 4'h8, 32'h3, 32'h0, 1, 1, 0, 0, 0);
        // Handshakes landing exactly on the expiry cycle win
        run_txn(1'b1, 4'hC, 32'h1, 32'h0, T, 1, 0, 0, 0);
        run_txn(1'b0, 4'h0, 32'h0, 32'hCAFE, 0, 0, 3, T, 0);

        // Randomized transactions within the timeout window
        for (int i = 0; i < 24; i++) begin
            bit wr;
            int a, b;
            wr = 1'($urandom_range(0, 1));
            a  = $urandom_range(1, 7);
            b  = $urandom_range(1, 7);
            if (wr) run_txn(1'b1, 4'($urandom), $urandom, 32'h0, a, b, 0, 0, $urandom_range(0, 3));
            else    run_txn(1'b0, 4'($urandom), 32'h0, $urandom, 0, 0, a, a + b, $urandom_range(0, 3));
        end

        // Reset mid-read while in the data phase
        chk("cmd_ready_pre_rst_read", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        chk("rready_before_rst", 32'(rready), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_arvalid", 32'(arvalid), 32'd0);
        chk("rst_mid_rready", 32'(rready), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("cmd_ready_after_mid_rst", 32'(cmd_ready), 32'd1);
        chk("rsp_valid_after_mid_rst", 32'(rsp_valid), 32'd0);
        run_txn(1'b1, 4'h8, 32'h2, 32'h0, 2, 2, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
